// File: rtl/mem_access_pkg.sv
// Shared funct3 codes, FSM state type and request-decode helpers for mem_access_unit.
// MISALIGN_SPLIT_EN adds the split-access states to the state type.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StRdWait  = 3'd2,
`ifdef MISALIGN_SPLIT_EN
    StSplitLo = 3'd3,
    StSplitHi = 3'd4,
    StStBytes = 3'd5,
`endif
    StResp    = 3'd6
  } mau_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores only have byte/half/word forms; the unsigned codes are load-only.
  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return !(funct3 inside {F3_B, F3_H, F3_W});
    end
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts a byte/half/word from a 64-bit {hi,lo} window at a byte offset and extends it.
module lsu_load_align
  import mem_access_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = 32'(window >> {offset, 3'b000});

  always_comb begin
    result = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and datamemory, one request at a time.
// Define MISALIGN_SPLIT_EN to split misaligned half/word accesses; otherwise they fault.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  access_fault,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  mau_state_t            state_q;
  logic                  write_q;
  logic                  rsp_valid_q;
  logic                  fault_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0] mdata_q;
  logic [2:0]            mf3_q;

  logic illegal;
  logic misaligned;
  logic reject;

  assign illegal    = is_illegal(req_write, req_funct3);
  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);

`ifdef MISALIGN_SPLIT_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [1:0]            byte_idx_q;
  logic [1:0]            last_idx_q;
  logic [1:0]            next_idx;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] split_rdata;

  assign reject    = illegal;
  assign next_idx  = byte_idx_q + 2'd1;
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_load_align u_load_align (
    .window (64'({mem_data_out, lo_q})),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (split_rdata)
  );
`else
  assign reject = illegal || misaligned;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      maddr_q     <= '0;
      mdata_q     <= '0;
      mf3_q       <= '0;
`ifdef MISALIGN_SPLIT_EN
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      lo_q        <= '0;
      byte_idx_q  <= '0;
      last_idx_q  <= '0;
`endif
    end else begin
      // Memory strobes and the response are single-cycle unless a state re-asserts them.
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      maddr_q     <= '0;
      mdata_q     <= '0;
      mf3_q       <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q <= req_write;
`ifdef MISALIGN_SPLIT_EN
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
`endif
            if (reject) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              fault_q     <= 1'b1;
            end
`ifdef MISALIGN_SPLIT_EN
            else if (misaligned && req_write) begin
              state_q    <= StStBytes;
              wr_en_q    <= 1'b1;
              maddr_q    <= req_addr;
              mdata_q    <= DATA_WIDTH'(req_wdata[7:0]);
              mf3_q      <= F3_B;
              byte_idx_q <= 2'd0;
              last_idx_q <= (req_funct3 == F3_H) ? 2'd1 : 2'd3;
            end else if (misaligned) begin
              state_q <= StSplitLo;
              rd_en_q <= 1'b1;
              maddr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mf3_q   <= F3_W;
            end
`endif
            else begin
              state_q <= StIssue;
              maddr_q <= req_addr;
              mf3_q   <= req_funct3;
              if (req_write) begin
                wr_en_q     <= 1'b1;
                mdata_q     <= req_wdata;
                rsp_valid_q <= 1'b1;
              end else begin
                rd_en_q <= 1'b1;
              end
            end
          end
        end
        StIssue: begin
          if (write_q) begin
            state_q <= StIdle;
          end else begin
            state_q     <= StRdWait;
            rsp_valid_q <= 1'b1;
          end
        end
        StRdWait: state_q <= StIdle;
        StResp:   state_q <= StIdle;
`ifdef MISALIGN_SPLIT_EN
        StSplitLo: begin
          state_q <= StSplitHi;
          rd_en_q <= 1'b1;
          maddr_q <= word_addr + ADDR_WIDTH'(4);
          mf3_q   <= F3_W;
        end
        StSplitHi: begin
          // Low word from the SPLIT_LO read is on mem_data_out now; high word lands in RESP.
          lo_q        <= mem_data_out;
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end
        StStBytes: begin
          if (byte_idx_q == last_idx_q) begin
            state_q <= StIdle;
          end else begin
            byte_idx_q  <= next_idx;
            wr_en_q     <= 1'b1;
            maddr_q     <= addr_q + ADDR_WIDTH'(next_idx);
            mdata_q     <= DATA_WIDTH'(wdata_q[{next_idx, 3'b000} +: 8]);
            mf3_q       <= F3_B;
            rsp_valid_q <= (next_idx == last_idx_q);
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (state_q == StRdWait) begin
      rsp_rdata = mem_data_out;
    end
`ifdef MISALIGN_SPLIT_EN
    else if (state_q == StResp && !fault_q) begin
      rsp_rdata = split_rdata;
    end
`endif
  end

  assign req_ready    = (state_q == StIdle) && !reset;
  assign rsp_valid    = rsp_valid_q;
  assign access_fault = fault_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign mem_address  = maddr_q;
  assign mem_data_in  = mdata_q;
  assign mem_funct3   = mf3_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a little-endian byte-array datamemory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        access_fault;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [11:0] mem_address;
  logic [31:0] mem_data_in;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_data_out = '0;

  int checks = 0;
  int errors = 0;

  logic [4:0] ctl;
  assign ctl = {mem_write_en, mem_read_en, rsp_valid, access_fault, req_ready};

  mem_access_unit #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .access_fault (access_fault),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_funct3   (mem_funct3),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  // datamemory model: synchronous read, extension done here per funct3
  logic [7:0] mem [0:4095];
  always @(posedge clock) begin
    if (mem_write_en) begin
      mem[mem_address] <= mem_data_in[7:0];
      if (mem_funct3 != 3'b000) mem[mem_address + 12'd1] <= mem_data_in[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_address + 12'd2] <= mem_data_in[23:16];
        mem[mem_address + 12'd3] <= mem_data_in[31:24];
      end
    end
    if (mem_read_en) begin
      case (mem_funct3)
        3'b000:  mem_data_out <= {{24{mem[mem_address][7]}}, mem[mem_address]};
        3'b100:  mem_data_out <= {24'b0, mem[mem_address]};
        3'b001:  mem_data_out <= {{16{mem[mem_address + 12'd1][7]}}, mem[mem_address + 12'd1],
                                  mem[mem_address]};
        3'b101:  mem_data_out <= {16'b0, mem[mem_address + 12'd1], mem[mem_address]};
        default: mem_data_out <= {mem[mem_address + 12'd3], mem[mem_address + 12'd2],
                                  mem[mem_address + 12'd1], mem[mem_address]};
      endcase
    end
  end

  // Presents a request for exactly one rising edge; call just after a falling edge.
  task automatic send(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [2:0] f3);
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    req_valid  = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic mem_op(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output logic [31:0] rd, output logic flt);
    int n = 0;
    send(wr, a, d, f3);
    @(negedge clock);
    while (rsp_valid !== 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mem_op_timeout: addr %h rsp_valid %b want 1", a, rsp_valid);
    end
    rd  = rsp_rdata;
    flt = access_fault;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ctl !== 5'b00000 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl %b rdata %h want 00000 0", ctl, rsp_rdata);
    end
    checks++;
    if (mem_address !== 12'h0 || mem_data_in !== 32'h0 || mem_funct3 !== 3'b0) begin
      errors++;
      $display("FAIL reset_mem: addr %h data %h f3 %b want 0", mem_address, mem_data_in,
               mem_funct3);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ready: ctl %b want 00001", ctl);
    end
  endtask

  task automatic test_aligned_store();
    send(1'b1, 12'h010, 32'h12345678, 3'b010);
    @(negedge clock);
    checks++;
    if (ctl !== 5'b10100) begin
      errors++;
      $display("FAIL st_ctl: ctl %b want 10100", ctl);
    end
    checks++;
    if (mem_address !== 12'h010 || mem_data_in !== 32'h12345678 || mem_funct3 !== 3'b010) begin
      errors++;
      $display("FAIL st_bus: addr %h data %h f3 %b want 010 12345678 010", mem_address,
               mem_data_in, mem_funct3);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001 || mem_address !== 12'h0 || mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL st_idle: ctl %b addr %h data %h want 00001 0 0", ctl, mem_address,
               mem_data_in);
    end
  endtask

  task automatic test_aligned_load();
    send(1'b0, 12'h010, 32'h0, 3'b010);
    @(negedge clock);
    checks++;
    if (ctl !== 5'b01000 || mem_address !== 12'h010 || mem_funct3 !== 3'b010) begin
      errors++;
      $display("FAIL ld_issue: ctl %b addr %h f3 %b want 01000 010 010", ctl, mem_address,
               mem_funct3);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00100 || rsp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL ld_rsp: ctl %b rdata %h want 00100 12345678", ctl, rsp_rdata);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++;
      $display("FAIL ld_idle: ctl %b want 00001", ctl);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [11:0] adrs [5] = '{12'h011, 12'h011, 12'h012, 12'h012, 12'h010};
    logic [31:0] exps [5] = '{32'hFFFFFFCC, 32'h000000CC, 32'hFFFFAABB, 32'h0000AABB,
                              32'hAABBCCDD};
    logic [31:0] rd;
    logic        flt;
    mem_op(1'b1, 12'h010, 32'hAABBCCDD, 3'b010, rd, flt);
    for (int i = 0; i < 5; i++) begin
      mem_op(1'b0, adrs[i], 32'h0, f3s[i], rd, flt);
      checks++;
      if (rd !== exps[i] || flt !== 1'b0) begin
        errors++;
        $display("FAIL ld_ext%0d: rdata %h fault %b want %h 0", i, rd, flt, exps[i]);
      end
    end
  endtask

  task automatic test_fault();
    logic       wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] f3s [4] = '{3'b011, 3'b100, 3'b111, 3'b110};
    for (int i = 0; i < 4; i++) begin
      send(wrs[i], 12'h000, 32'hDEADBEEF, f3s[i]);
      @(negedge clock);
      checks++;
      if (ctl !== 5'b00110 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL fault%0d_rsp: ctl %b rdata %h want 00110 0", i, ctl, rsp_rdata);
      end
      @(negedge clock);
      checks++;
      if (ctl !== 5'b00001) begin
        errors++;
        $display("FAIL fault%0d_idle: ctl %b want 00001", i, ctl);
      end
    end
  endtask

`ifdef MISALIGN_SPLIT_EN
  task automatic test_misaligned();
    logic [2:0]  f3s  [3] = '{3'b001, 3'b001, 3'b101};
    logic [11:0] adrs [3] = '{12'h013, 12'h011, 12'h011};
    logic [31:0] exps [3] = '{32'h000044AA, 32'hFFFFBBCC, 32'h0000BBCC};
    logic [31:0] wd = 32'hCAFEF00D;
    logic [11:0] ea;
    logic [31:0] rd;
    logic        flt;
    mem_op(1'b1, 12'h010, 32'hAABBCCDD, 3'b010, rd, flt);
    mem_op(1'b1, 12'h014, 32'h11223344, 3'b010, rd, flt);
    send(1'b0, 12'h012, 32'h0, 3'b010);
    @(negedge clock);
    checks++;
    if (ctl !== 5'b01000 || mem_address !== 12'h010 || mem_funct3 !== 3'b010) begin
      errors++;
      $display("FAIL split_lo: ctl %b addr %h f3 %b want 01000 010 010", ctl, mem_address,
               mem_funct3);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b01000 || mem_address !== 12'h014 || mem_funct3 !== 3'b010) begin
      errors++;
      $display("FAIL split_hi: ctl %b addr %h f3 %b want 01000 014 010", ctl, mem_address,
               mem_funct3);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00100 || rsp_rdata !== 32'h3344AABB) begin
      errors++;
      $display("FAIL split_rsp: ctl %b rdata %h want 00100 3344aabb", ctl, rsp_rdata);
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      mem_op(1'b0, adrs[i], 32'h0, f3s[i], rd, flt);
      checks++;
      if (rd !== exps[i] || flt !== 1'b0) begin
        errors++;
        $display("FAIL split_ld%0d: rdata %h fault %b want %h 0", i, rd, flt, exps[i]);
      end
    end
    mem_op(1'b1, 12'h020, 32'h0, 3'b010, rd, flt);
    send(1'b1, 12'h021, 32'h0000BEEF, 3'b001);
    @(negedge clock);
    checks++;
    if (ctl !== 5'b10000 || mem_address !== 12'h021 || mem_data_in !== 32'hEF ||
        mem_funct3 !== 3'b000) begin
      errors++;
      $display("FAIL sh_b0: ctl %b addr %h data %h f3 %b want 10000 021 ef 000", ctl,
               mem_address, mem_data_in, mem_funct3);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b10100 || mem_address !== 12'h022 || mem_data_in !== 32'hBE) begin
      errors++;
      $display("FAIL sh_b1: ctl %b addr %h data %h want 10100 022 be", ctl, mem_address,
               mem_data_in);
    end
    @(negedge clock);
    mem_op(1'b0, 12'h020, 32'h0, 3'b010, rd, flt);
    checks++;
    if (rd !== 32'h00BEEF00) begin
      errors++;
      $display("FAIL sh_readback: rdata %h want 00beef00", rd);
    end
    mem_op(1'b1, 12'h000, 32'h0, 3'b010, rd, flt);
    send(1'b1, 12'hFFE, wd, 3'b010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      ea = 12'hFFE + 12'(k);
      checks++;
      if (mem_write_en !== 1'b1 || mem_address !== ea || mem_data_in !== {24'b0, wd[8*k +: 8]} ||
          rsp_valid !== (k == 3)) begin
        errors++;
        $display("FAIL sw_wrap_b%0d: we %b addr %h data %h rv %b want 1 %h %h %b", k,
                 mem_write_en, mem_address, mem_data_in, rsp_valid, ea, wd[8*k +: 8], k == 3);
      end
    end
    @(negedge clock);
    mem_op(1'b0, 12'h000, 32'h0, 3'b010, rd, flt);
    checks++;
    if (rd !== 32'h0000CAFE) begin
      errors++;
      $display("FAIL sw_wrap_readback: rdata %h want 0000cafe", rd);
    end
  endtask
`else
  task automatic test_misaligned();
    logic        wrs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] adrs [4] = '{12'h002, 12'h021, 12'h013, 12'h022};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b001, 3'b010};
    logic [31:0] rd;
    logic        flt;
    mem_op(1'b1, 12'h020, 32'h55AA55AA, 3'b010, rd, flt);
    for (int i = 0; i < 4; i++) begin
      send(wrs[i], adrs[i], 32'h0000BEEF, f3s[i]);
      @(negedge clock);
      checks++;
      if (ctl !== 5'b00110) begin
        errors++;
        $display("FAIL misal%0d_rsp: ctl %b want 00110", i, ctl);
      end
      @(negedge clock);
    end
    mem_op(1'b0, 12'h020, 32'h0, 3'b010, rd, flt);
    checks++;
    if (rd !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL misal_untouched: rdata %h want 55aa55aa", rd);
    end
  endtask
`endif

  task automatic test_back_to_back();
    req_write  = 1'b1;
    req_addr   = 12'h040;
    req_wdata  = 32'h0F0F0F0F;
    req_funct3 = 3'b010;
    req_valid  = 1'b1;
    @(posedge clock);
    #1 req_write = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b10100) begin
      errors++;
      $display("FAIL b2b_store: ctl %b want 10100", ctl);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++;
      $display("FAIL b2b_gap: ctl %b want 00001", ctl);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b01000 || mem_address !== 12'h040) begin
      errors++;
      $display("FAIL b2b_load_issue: ctl %b addr %h want 01000 040", ctl, mem_address);
    end
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00100 || rsp_rdata !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL b2b_load_rsp: ctl %b rdata %h want 00100 0f0f0f0f", ctl, rsp_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    send(1'b0, 12'h010, 32'h0, 3'b010);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_ld: ctl %b want 00000", ctl);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_ld_after: ctl %b want 00001", ctl);
    end
`ifdef MISALIGN_SPLIT_EN
    send(1'b0, 12'h012, 32'h0, 3'b010);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_split: ctl %b want 00000", ctl);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_split_after: ctl %b want 00001", ctl);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned_store();
    test_aligned_load();
    test_load_ext();
    test_fault();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the MEM pipeline stage and `datamemory`. It accepts one load or store request at a time, drives the data memory's read/write/address/data/funct3 inputs, and returns a single-cycle response. Optionally it splits misaligned halfword/word accesses into several aligned memory transactions. It stalls the pipeline through `req_ready`.

## Interface
- `ADDR_WIDTH`, 12: byte address width; must match `datamemory`.
- `DATA_WIDTH`, 32: data width; only 32 is supported.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the unit can accept a request (IDLE only).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data; the value sits in the low bits.
- `req_funct3` in 3: RISC-V insn[14:12].
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `rsp_rdata` out 32: load result, extended; 0 for stores.
- `access_fault` out 1: qualified by `rsp_valid`; the request was rejected.
- `mem_read_en`, `mem_write_en` out 1: drive `datamemory` `read_en` and `write_en`.
- `mem_address` out ADDR_WIDTH; `mem_data_in` out 32; `mem_funct3` out 3.
- `mem_data_out` in 32: memory read data. It is valid in the cycle after `mem_read_en`.

## Operation
- Handshake: the unit accepts a request at the edge where `req_valid && req_ready`, and latches all request fields. `req_ready` is 1 only in IDLE, and 0 while `reset` is high.
- Alignment: LB/LBU/SB are always aligned. LH/LHU/SH are misaligned when addr[0]=1. LW/SW are misaligned when addr[1:0]≠0.
- Illegal funct3 (011, 110, 111, and 100/101 for stores) is rejected: fault response, no memory enable asserted.
- States: IDLE, ISSUE, RD_WAIT, SPLIT_LO, SPLIT_HI, ST_BYTES, RESP.
- Aligned store (IDLE→ISSUE):
  - `mem_write_en`=1 for one cycle, with `mem_address`=addr, `mem_funct3`=funct3, `mem_data_in`=wdata.
  - `rsp_valid` is asserted in the same cycle.
  - Next state IDLE.
- Aligned load (IDLE→ISSUE→RD_WAIT):
  - ISSUE: `mem_read_en`=1 and `mem_funct3`=funct3; the memory performs the extension.
  - RD_WAIT: `rsp_valid`=1 and `rsp_rdata`=`mem_data_out`.
  - Next state IDLE.
- Misaligned load (IDLE→SPLIT_LO→SPLIT_HI):
  - SPLIT_LO: read the word at {addr[hi:2],00} with `mem_funct3`=010.
  - SPLIT_HI: latch `mem_data_out` as lo, then read the next word (address +4, wrapping modulo 2^ADDR_WIDTH).
  - RESP: form {hi,lo} as a 64-bit window, extract bytes starting at offset addr[1:0], then sign- or zero-extend per funct3. Assert `rsp_valid`.
  - Total latency is 3 cycles after acceptance.
- Misaligned store (IDLE→ST_BYTES):
  - Issues N byte writes (SB, funct3=000), one per cycle. N=2 for SH and N=4 for SW.
  - Byte k goes to addr+k, wrapping, with `mem_data_in`={24'b0, wdata[8k+7:8k]}.
  - `rsp_valid` is asserted in the cycle of the last write.
- Rejection: in the cycle after acceptance, `rsp_valid`=1 and `access_fault`=1, with no memory enables. Next state IDLE.
- `mem_read_en` and `mem_write_en` are never both 1.
- Outside an issuing cycle, `mem_*` outputs are 0.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after; all other outputs 0. State goes to IDLE.
- Latency from acceptance edge T to response:
  - aligned store T+1
  - aligned load T+2
  - misaligned load T+3
  - misaligned SH T+2
  - misaligned SW T+4
  - fault T+1
- The next request can be accepted no earlier than the cycle after `rsp_valid`. The unit never accepts a request and responds in the same cycle.
- Reset mid-operation: the transfer is abandoned at that edge and enables drop immediately. Byte writes already issued stay committed. No response is generated.
- Address wrap: addr=0xFFE with SW splits to bytes at 0xFFE, 0xFFF, 0x000, 0x001.

## Configuration
- `MISALIGN_SPLIT_EN` defined: misaligned accesses are split as described above; `access_fault` is raised only for illegal funct3.
- `MISALIGN_SPLIT_EN` undefined:
  - SPLIT_LO, SPLIT_HI and ST_BYTES are absent.
  - Misaligned requests are rejected like illegal funct3: fault at T+1, no memory access.

## Structure
- Package `mem_access_pkg` holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state enum `mau_state_t`
  - a `is_misaligned(funct3, addr[1:0])` function
- Sub-module `lsu_load_align`: combinational. Inputs are the 64-bit window, offset[1:0] and funct3; output is the 32-bit extended result.

## Test plan
- Aligned SW 0x12345678 @0x010, then LW @0x010 → write at T+1; load `rsp_rdata`=0x12345678 at T+2, `access_fault`=0.
- Memory 0x010=0xAABBCCDD, 0x014=0x11223344; LW @0x012 → reads 0x010 then 0x014, `rsp_rdata`=0x3344AABB at T+3. LH @0x013 → 0x000044AA; LHU @0x011 sign case with bytes 0xBBCC → LH gives 0xFFFFBBCC, LHU gives 0x0000BBCC.
- SH 0xBEEF @0x021 → SB 0xEF@0x021 at T+1, SB 0xBE@0x022 at T+2, `rsp_valid` at T+2; LW @0x020 then shows 0x00BEEF00 over a zeroed word.
- SW @0xFFE → byte writes at 0xFFE, 0xFFF, 0x000, 0x001; LW @0x000 shows the upper half of the data in bits [15:0].
- funct3=011 load @0x000 → `rsp_valid`=`access_fault`=1 at T+1, no enables. With `MISALIGN_SPLIT_EN` undefined, LW @0x002 behaves the same way.
- `reset` asserted during SPLIT_HI → enables 0 at the next edge, no `rsp_valid`, `req_ready`=1 in the first cycle after reset.
